captura_instrucao: RTL and testbench
====================================

# captura_instrucao

Instruction-capture stage directly upstream of the board-level ALU. Synchronizes and debounces the DE2 execute and clear pushbuttons, latches the 16-bit instruction word from the switches, and issues it to the ALU/register-bank stage through a valid/ready handshake, one instruction per button press. Also keeps an 8-bit issued-instruction counter for the HEX displays.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required to accept a button level change (≥2).
- clk  in  1  system clock (50 MHz on board).
- reset  in  1  asynchronous, active-low reset.
- sw  in  16  instruction word: [15:12] codop, [11:8] rd, [7:4] rs/immediate, [3:0] rt.
- key_exec  in  1  raw execute pushbutton, active-low (pressed = 0).
- key_clear  in  1  raw clear pushbutton, active-low.
- ready  in  1  ALU stage can accept an instruction this cycle.
- valid  out  1  instruction outputs hold a pending instruction.
- codop  out  4  latched sw[15:12].
- end_rd  out  4  latched sw[11:8].
- end_rs  out  4  latched sw[7:4].
- end_rt  out  4  latched sw[3:0].
- instr_count  out  8  instructions transferred since reset/clear.
- err  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- Reset (reset=0, async): valid=0, codop/end_rd/end_rs/end_rt=0, instr_count=0, err=0, state IDLE, sync and debounce registers cleared to "released" (1).
- sw, key_exec, key_clear pass through 2-flop synchronizers; all logic uses synchronized values.
- Debounce counter for key_exec: counts consecutive cycles the synchronized level differs from the accepted level; resets to 0 on any agreement; accepted level toggles when count reaches DEBOUNCE_CYCLES.
- FSM:
  - IDLE: on accepted exec press → latch synchronized sw into output fields, valid=1, go ISSUE.
  - ISSUE: valid held, fields frozen. Transfer when valid&&ready: valid=0 next cycle, instr_count+1 (wraps 255→0), go WAIT_RELEASE.
  - WAIT_RELEASE: wait for accepted exec release → IDLE. Holding the button issues exactly one instruction.
- Clear: synchronized key_clear=0 (no debounce; idempotent) in any state → valid=0, fields=0, instr_count=0, err=0, go WAIT_RELEASE. Clear has priority over a same-cycle transfer or press; the transfer is lost and not counted.
- ready is ignored outside ISSUE. sw changes after capture do not affect outputs.

## Timing
- Exec press stable from before edge 0: synchronized low after edge 2; valid=1 after edge 2+DEBOUNCE_CYCLES.
- Fields valid the same cycle valid rises; stable until transfer.
- ready=1 while valid=1: transfer on that edge; valid=0 and instr_count updated after it (1-cycle handshake).
- Release accepted 2+DEBOUNCE_CYCLES edges after raw release; next press counted only from IDLE.
- Glitch shorter than DEBOUNCE_CYCLES cycles: no state change.
- Clear effect visible 3 edges after raw key_clear falls (2 sync + 1 register).

## Configuration
- OPCODE_CHECK_EN defined: on capture, codop > 4'b1010 sets err=1 (sticky until reset/clear), valid stays 0, instr_count unchanged, FSM goes straight to WAIT_RELEASE.
- Not defined: every codop is issued normally; err tied to 0.

## Test plan
- DEBOUNCE_CYCLES=4, sw=16'h0123, press exec, ready=1 → valid high exactly 6 cycles after press for 1 cycle, codop=0, end_rd=1, end_rs=2, end_rt=3, instr_count=1.
- ready=0 for 10 cycles after valid, sw changed to 16'hFFFF meanwhile → valid and fields (0123) held; transfer on first ready=1, count increments once.
- Exec held 100 cycles, ready=1 → exactly one transfer; 3-cycle low glitch on exec → no transfer.
- 256 press/release cycles → instr_count wraps to 0; clear asserted mid-ISSUE with ready=1 same cycle → valid=0, count=0, no transfer.
- OPCODE_CHECK_EN defined, sw=16'hB000 press → err=1, valid never rises, count unchanged; then sw=16'h1000 press → issued normally, err stays 1 until clear.
- reset driven low mid-ISSUE between clock edges → all outputs 0 immediately, no clock required.

Source files
------------

// File: rtl/captura_instrucao.sv
// Instruction capture: synchronizes/debounces DE2 keys, latches sw, issues via valid/ready.
// Optional OPCODE_CHECK_EN: opcodes above 4'b1010 set a sticky err instead of issuing.
module captura_instrucao #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic        key_exec,
  input  logic        key_clear,
  input  logic        ready,
  output logic        valid,
  output logic [3:0]  codop,
  output logic [3:0]  end_rd,
  output logic [3:0]  end_rs,
  output logic [3:0]  end_rt,
  output logic [7:0]  instr_count,
  output logic        err
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] ISSUE        = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;

  logic [15:0]   sw_s1, sw_s2;
  logic          exec_s1, exec_s2, clr_s1, clr_s2;
  logic          exec_acc;
  logic [CW-1:0] db_cnt;
  logic [1:0]    state;
  logic          press_evt;
  logic          illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      exec_s1 <= 1'b1;
      exec_s2 <= 1'b1;
      clr_s1  <= 1'b1;
      clr_s2  <= 1'b1;
    end else begin
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
      exec_s1 <= key_exec;
      exec_s2 <= exec_s1;
      clr_s1  <= key_clear;
      clr_s2  <= clr_s1;
    end
  end

  // Press event fires on the same edge the accepted level toggles, so the FSM
  // captures without an extra cycle of latency.
  assign press_evt = (exec_s2 == 1'b0) && (exec_acc == 1'b1) && (db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_acc <= 1'b1;
      db_cnt   <= '0;
    end else if (exec_s2 == exec_acc) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      exec_acc <= exec_s2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

`ifdef OPCODE_CHECK_EN
  assign illegal = sw_s2[15:12] > 4'd10;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (!clr_s2) begin
      err <= 1'b0;
    end else if (state == IDLE && press_evt && illegal) begin
      err <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      valid       <= 1'b0;
      codop       <= '0;
      end_rd      <= '0;
      end_rs      <= '0;
      end_rt      <= '0;
      instr_count <= '0;
    end else if (!clr_s2) begin
      state       <= WAIT_RELEASE;
      valid       <= 1'b0;
      codop       <= '0;
      end_rd      <= '0;
      end_rs      <= '0;
      end_rt      <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press_evt) begin
            if (illegal) begin
              state <= WAIT_RELEASE;
            end else begin
              codop  <= sw_s2[15:12];
              end_rd <= sw_s2[11:8];
              end_rs <= sw_s2[7:4];
              end_rt <= sw_s2[3:0];
              valid  <= 1'b1;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (ready) begin
            valid       <= 1'b0;
            instr_count <= instr_count + 8'd1;
            state       <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (exec_acc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_captura_instrucao.sv
// Self-checking bench for captura_instrucao with DEBOUNCE_CYCLES=4 and a transaction-level model.
module tb_captura_instrucao;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw;
  logic        key_exec, key_clear, ready;
  logic        valid, err;
  logic [3:0]  codop, end_rd, end_rs, end_rt;
  logic [7:0]  instr_count;

  int errors = 0;
  int checks = 0;

  // Reference model: issued-instruction count and sticky error flag.
  int unsigned exp_count = 0;
  logic        exp_err   = 1'b0;

  captura_instrucao #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sw(sw), .key_exec(key_exec), .key_clear(key_clear),
    .ready(ready), .valid(valid), .codop(codop), .end_rd(end_rd), .end_rs(end_rs),
    .end_rt(end_rt), .instr_count(instr_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_illegal(input logic [15:0] w);
`ifdef OPCODE_CHECK_EN
    return w[15:12] > 4'd10;
`else
    return 1'b0;
`endif
  endfunction

  task automatic release_exec();
    key_exec = 1'b1;
    ready    = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; sw = '0; key_exec = 1'b1; key_clear = 1'b1; ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({valid, codop, end_rd, end_rs, end_rt, instr_count, err} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b fields=%h count=%0d err=%b, expected all 0",
               valid, {codop, end_rd, end_rs, end_rt}, instr_count, err);
    end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    sw = 16'h0123; key_exec = 1'b0; ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL basic_early: valid=%b after 5 edges, expected 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || {codop, end_rd, end_rs, end_rt} !== 16'h0123) begin
      errors++;
      $display("FAIL basic_issue: valid=%b fields=%h after 6 edges, expected 1/0123",
               valid, {codop, end_rd, end_rs, end_rt});
    end
    tick();
    exp_count = (exp_count + 1) % 256;
    checks++;
    if (valid !== 1'b0 || instr_count !== exp_count[7:0]) begin
      errors++;
      $display("FAIL basic_transfer: valid=%b count=%0d, expected 0/%0d", valid, instr_count, exp_count);
    end
    release_exec();
  endtask

  task automatic test_backpressure();
    sw = 16'h0123; key_exec = 1'b0; ready = 1'b0;
    repeat (6) tick();
    sw = 16'hFFFF;
    repeat (10) tick();
    checks++;
    if (valid !== 1'b1 || {codop, end_rd, end_rs, end_rt} !== 16'h0123 || instr_count !== exp_count[7:0]) begin
      errors++;
      $display("FAIL hold_fields: valid=%b fields=%h count=%0d, expected 1/0123/%0d",
               valid, {codop, end_rd, end_rs, end_rt}, instr_count, exp_count);
    end
    ready = 1'b1;
    repeat (3) tick();
    exp_count = (exp_count + 1) % 256;
    checks++;
    if (valid !== 1'b0 || instr_count !== exp_count[7:0]) begin
      errors++;
      $display("FAIL hold_transfer: valid=%b count=%0d, expected 0/%0d", valid, instr_count, exp_count);
    end
    release_exec();
  endtask

  task automatic test_held_and_glitch();
    int high_cycles = 0;
    sw = 16'h2345; key_exec = 1'b0; ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid === 1'b1) high_cycles++;
    end
    exp_count = (exp_count + 1) % 256;
    checks++;
    if (high_cycles != 1 || instr_count !== exp_count[7:0]) begin
      errors++;
      $display("FAIL held_once: valid_cycles=%0d count=%0d, expected 1/%0d", high_cycles, instr_count, exp_count);
    end
    release_exec();
    high_cycles = 0;
    ready = 1'b1;
    key_exec = 1'b0;
    repeat (3) tick();
    key_exec = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid === 1'b1) high_cycles++;
    end
    checks++;
    if (high_cycles != 0 || instr_count !== exp_count[7:0]) begin
      errors++;
      $display("FAIL glitch: valid_cycles=%0d count=%0d, expected 0/%0d", high_cycles, instr_count, exp_count);
    end
    ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] w;
    int unsigned d;
    for (int n = 0; n < 24; n++) begin
      w = 16'($urandom);
      d = $urandom_range(0, 5);
      sw = w; key_exec = 1'b0; ready = 1'b0;
      repeat (6) tick();
      sw = 16'($urandom);
      if (is_illegal(w)) begin
        exp_err = 1'b1;
        checks++;
        if (valid !== 1'b0 || err !== 1'b1 || instr_count !== exp_count[7:0]) begin
          errors++;
          $display("FAIL rand_illegal[%0d]: valid=%b err=%b count=%0d, expected 0/1/%0d",
                   n, valid, err, instr_count, exp_count);
        end
      end else begin
        repeat (d) tick();
        checks++;
        if (valid !== 1'b1 || {codop, end_rd, end_rs, end_rt} !== w || err !== exp_err) begin
          errors++;
          $display("FAIL rand_issue[%0d]: valid=%b fields=%h err=%b, expected 1/%h/%b",
                   n, valid, {codop, end_rd, end_rs, end_rt}, err, w, exp_err);
        end
        ready = 1'b1;
        tick();
        exp_count = (exp_count + 1) % 256;
        checks++;
        if (valid !== 1'b0 || instr_count !== exp_count[7:0]) begin
          errors++;
          $display("FAIL rand_transfer[%0d]: valid=%b count=%0d, expected 0/%0d", n, valid, instr_count, exp_count);
        end
      end
      release_exec();
    end
  endtask

`ifdef OPCODE_CHECK_EN
  task automatic test_opcode_check();
    sw = 16'hB000; key_exec = 1'b0; ready = 1'b1;
    repeat (10) tick();
    exp_err = 1'b1;
    checks++;
    if (valid !== 1'b0 || err !== 1'b1 || instr_count !== exp_count[7:0]) begin
      errors++;
      $display("FAIL opcode_bad: valid=%b err=%b count=%0d, expected 0/1/%0d", valid, err, instr_count, exp_count);
    end
    release_exec();
    sw = 16'h1000; key_exec = 1'b0; ready = 1'b1;
    repeat (8) tick();
    exp_count = (exp_count + 1) % 256;
    checks++;
    if (err !== 1'b1 || instr_count !== exp_count[7:0]) begin
      errors++;
      $display("FAIL opcode_good: err=%b count=%0d, expected 1/%0d", err, instr_count, exp_count);
    end
    release_exec();
  endtask
`endif

  task automatic test_wrap_and_clear();
    key_clear = 1'b0;
    repeat (3) tick();
    exp_count = 0;
    exp_err = 1'b0;
    checks++;
    if (instr_count !== 8'd0 || err !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle: count=%0d err=%b valid=%b, expected 0/0/0", instr_count, err, valid);
    end
    key_clear = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 256; i++) begin
      sw = 16'(i); key_exec = 1'b0; ready = 1'b1;
      repeat (7) tick();
      exp_count = (exp_count + 1) % 256;
      release_exec();
      if (i == 254) begin
        checks++;
        if (instr_count !== 8'd255) begin
          errors++; $display("FAIL count_255: count=%0d, expected 255", instr_count);
        end
      end
    end
    checks++;
    if (instr_count !== exp_count[7:0]) begin
      errors++; $display("FAIL count_wrap: count=%0d, expected %0d", instr_count, exp_count);
    end
    sw = 16'h0456; key_exec = 1'b0; ready = 1'b0;
    repeat (6) tick();
    key_clear = 1'b0;
    repeat (2) tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL clear_pre: valid=%b two edges after clear, expected 1", valid);
    end
    ready = 1'b1;
    tick();
    exp_count = 0;
    checks++;
    if (valid !== 1'b0 || instr_count !== 8'd0 || {codop, end_rd, end_rs, end_rt} !== 16'h0) begin
      errors++;
      $display("FAIL clear_issue: valid=%b count=%0d fields=%h, expected 0/0/0000",
               valid, instr_count, {codop, end_rd, end_rs, end_rt});
    end
    key_clear = 1'b1;
    release_exec();
  endtask

  task automatic test_async_reset();
    sw = 16'h0789; key_exec = 1'b0; ready = 1'b0;
    repeat (6) tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre: valid=%b, expected 1", valid);
    end
    #2 reset = 1'b0;
    #1;
    exp_count = 0;
    exp_err = 1'b0;
    checks++;
    if ({valid, codop, end_rd, end_rs, end_rt, instr_count, err} !== 25'd0) begin
      errors++;
      $display("FAIL areset: valid=%b fields=%h count=%0d err=%b, expected all 0",
               valid, {codop, end_rd, end_rs, end_rt}, instr_count, err);
    end
    key_exec = 1'b1;
    tick();
    reset = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_held_and_glitch();
    test_random();
`ifdef OPCODE_CHECK_EN
    test_opcode_check();
`endif
    test_wrap_and_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
